// File: rtl/mux2x1_arb_feeder.sv
// mux2x1_arb_feeder
//   Feeder for the 2x1 mux stage. Two producers push WIDTH-bit words over valid/ready into
//   their own circular FIFO. A round-robin arbiter drains the FIFOs into a registered output
//   that drives the mux i0/i1/sel lines under an out_valid/out_ready handshake.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   in0_data/valid/ready   producer 0 handshake (ready depends on FIFO state only)
//   in1_data/valid/ready   producer 1 handshake
//   out_i0, out_i1         mux data lines; the non-granted line is driven to 0
//   out_sel                0: word on out_i0, 1: word on out_i1
//   out_valid, out_ready   consumer handshake
module mux2x1_arb_feeder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_i0,
    output logic [WIDTH-1:0] out_i1,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // FIFO 0 state
    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [WIDTH-1:0] mem0_d [DEPTH];
    logic [AW-1:0]    wr0_q, wr0_d, rd0_q, rd0_d;
    logic [CW-1:0]    cnt0_q, cnt0_d;

    // FIFO 1 state
    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [WIDTH-1:0] mem1_d [DEPTH];
    logic [AW-1:0]    wr1_q, wr1_d, rd1_q, rd1_d;
    logic [CW-1:0]    cnt1_q, cnt1_d;

    // Output register and arbiter state
    logic [WIDTH-1:0] out_i0_q, out_i0_d, out_i1_q, out_i1_d;
    logic             out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             last_grant_q, last_grant_d;

    logic push0, push1, pop0, pop1;
    logic ne0, ne1, load_en, grant;

    assign in0_ready = (cnt0_q != CW'(DEPTH));
    assign in1_ready = (cnt1_q != CW'(DEPTH));
    assign push0     = in0_valid && in0_ready;
    assign push1     = in1_valid && in1_ready;

    assign ne0     = (cnt0_q != '0);
    assign ne1     = (cnt1_q != '0);
    assign load_en = !out_valid_q || out_ready;

    // On a tie the channel that did not win the last tie goes; otherwise the only
    // non-empty channel. When both are empty grant is don't-care (no pop happens).
    always_comb begin
        grant = 1'b0;
        if (ne0 && ne1) begin
            grant = ~last_grant_q;
        end else if (ne1) begin
            grant = 1'b1;
        end
    end

    assign pop0 = load_en && ne0 && !grant;
    assign pop1 = load_en && ne1 && grant;

    // FIFO 0 next state
    always_comb begin
        mem0_d = mem0_q;
        wr0_d  = wr0_q;
        rd0_d  = rd0_q;
        cnt0_d = cnt0_q;
        if (push0) begin
            mem0_d[wr0_q] = in0_data;
            wr0_d         = wr0_q + AW'(1);
        end
        if (pop0) begin
            rd0_d = rd0_q + AW'(1);
        end
        unique case ({push0, pop0})
            2'b10:   cnt0_d = cnt0_q + CW'(1);
            2'b01:   cnt0_d = cnt0_q - CW'(1);
            default: cnt0_d = cnt0_q;
        endcase
    end

    // FIFO 1 next state
    always_comb begin
        mem1_d = mem1_q;
        wr1_d  = wr1_q;
        rd1_d  = rd1_q;
        cnt1_d = cnt1_q;
        if (push1) begin
            mem1_d[wr1_q] = in1_data;
            wr1_d         = wr1_q + AW'(1);
        end
        if (pop1) begin
            rd1_d = rd1_q + AW'(1);
        end
        unique case ({push1, pop1})
            2'b10:   cnt1_d = cnt1_q + CW'(1);
            2'b01:   cnt1_d = cnt1_q - CW'(1);
            default: cnt1_d = cnt1_q;
        endcase
    end

    // Output register next state; data/sel hold when nothing is loaded
    always_comb begin
        out_i0_d     = out_i0_q;
        out_i1_d     = out_i1_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            if (ne0 || ne1) begin
                out_sel_d   = grant;
                out_valid_d = 1'b1;
                if (grant) begin
                    out_i0_d = '0;
                    out_i1_d = mem1_q[rd1_q];
                end else begin
                    out_i0_d = mem0_q[rd0_q];
                    out_i1_d = '0;
                end
                if (ne0 && ne1) begin
                    last_grant_d = grant;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem0_q[i] <= '0;
                mem1_q[i] <= '0;
            end
            wr0_q        <= '0;
            rd0_q        <= '0;
            cnt0_q       <= '0;
            wr1_q        <= '0;
            rd1_q        <= '0;
            cnt1_q       <= '0;
            out_i0_q     <= '0;
            out_i1_q     <= '0;
            out_sel_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            mem0_q       <= mem0_d;
            mem1_q       <= mem1_d;
            wr0_q        <= wr0_d;
            rd0_q        <= rd0_d;
            cnt0_q       <= cnt0_d;
            wr1_q        <= wr1_d;
            rd1_q        <= rd1_d;
            cnt1_q       <= cnt1_d;
            out_i0_q     <= out_i0_d;
            out_i1_q     <= out_i1_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_i0    = out_i0_q;
    assign out_i1    = out_i1_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/mux2x1_arb_feeder.md
# mux2x1_arb_feeder

Upstream feeder for the 2x1 mux stage. It accepts 4-bit words from two independent producers over valid/ready handshakes and buffers each stream in its own FIFO. A round-robin arbiter drains the FIFOs into a registered output that drives the mux's `i0`, `i1` and `sel` lines, with an `out_valid`/`out_ready` handshake.

## Interface
- `WIDTH`, 4: data width of every data port.
- `DEPTH`, 4: entries per input FIFO. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in0_data`  in  WIDTH  producer-0 word.
- `in0_valid`  in  1  producer-0 word valid.
- `in0_ready`  out  1  FIFO0 can accept.
- `in1_data`  in  WIDTH  producer-1 word.
- `in1_valid`  in  1  producer-1 word valid.
- `in1_ready`  out  1  FIFO1 can accept.
- `out_i0`  out  WIDTH  drives mux `i0`.
- `out_i1`  out  WIDTH  drives mux `i1`.
- `out_sel`  out  1  drives mux `sel`. 0 = `i0` carries the word, 1 = `i1` carries it.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- **FIFOs:** two per-channel circular FIFOs. Each has read/write pointers of width log2(DEPTH) and an occupancy counter of width log2(DEPTH)+1.
  - `inN_ready = (countN != DEPTH)`. This is combinational from state only, never from `inN_valid`.
  - Push when `inN_valid && inN_ready`. The write pointer wraps from DEPTH-1 to 0.
  - Push and pop on the same cycle: the count is unchanged.
  - A push is never allowed while full, even if a pop occurs in the same cycle.
- **Output register:** a load is permitted when `!out_valid || out_ready`. On a permitted cycle:
  - Neither FIFO is non-empty: `out_valid` becomes 0 and the data/sel registers hold.
  - Only one FIFO is non-empty: that channel is granted.
  - Both are non-empty: grant the channel ≠ `last_grant`, then update `last_grant`.
  - Granted channel g: `out_sel ← g`; the head of FIFO g goes to `out_i{g}`; the other line goes to 0; FIFO g pops; `out_valid ← 1`.
- **Stall:** while `out_valid && !out_ready`, `out_i0`, `out_i1`, `out_sel` and `out_valid` hold stable and no FIFO pops.
- **Reset** (synchronous, overrides all activity in that cycle, including mid-transfer):
  - All pointers and counts go to 0, so `in0_ready = in1_ready = 1` after the reset edge.
  - `out_valid = 0`, `out_i0 = out_i1 = 0`, `out_sel = 0`.
  - `last_grant = 1`, so channel 0 wins the first tie.
  - All buffered words are discarded.
- No data reordering within a channel. Each channel is strictly FIFO.

## Timing
- **Latency:** a word accepted at edge E is presented (`out_valid = 1`) after edge E+1 at the earliest. There is no combinational bypass from input to output.
- **Throughput:** with `out_ready` held at 1, one word leaves per cycle.
  - With both channels saturated, the channels strictly alternate 0,1,0,1…
- **Ready deassertion:** `inN_ready` drops in the cycle after the push that makes the count equal DEPTH. It rises in the cycle after the first pop from full.
- **Word transfer:** a word transfers on an edge where `out_valid && out_ready`. The next word may be loaded on that same edge.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in0_valid = 1`. Required: no push occurs, `out_valid = 0`, all outputs are 0, both readys are 1 after release.
- **Single channel:** push 4'hA then 4'h5 on ch0 with `out_ready = 1`. Required: 4'hA appears on `out_i0` with `out_sel = 0` one edge after acceptance, then 4'h5; `out_i1` stays 0.
- **Round-robin:** preload ch0 with {1,2} and ch1 with {9,8}, then raise `out_ready`. Required order is (sel0,1), (sel1,9), (sel0,2), (sel1,8).
- **Full boundary:** with `out_ready = 0`, push 5 words on ch1 (one goes to the output register, the next 4 fill FIFO1). Required:
  - `in1_ready = 0` after the 5th accepted word.
  - A 6th `in1_valid` is not accepted.
  - One `out_ready` pulse restores `in1_ready` on the next cycle.
- **Backpressure hold:** with `out_valid = 1` showing 4'h3 and `out_ready = 0` for 5 cycles while ch1 pushes continue. Required: the output stays 4'h3 with `sel = 0`, and nothing is popped.
- **Reset mid-stream:** with 3 words buffered, assert `rst` for 1 cycle. Required: counts return to 0, `out_valid = 0`, and the first post-reset tie grants ch0.
